// File: rtl/mem_access.sv
// mem_access: data-memory access stage between EX_MEM and MEM_WB.
// ALU-only instructions complete in one cycle with no stall. Aligned loads
// and stores run a two-state IDLE/ACCESS bus transaction. The upstream stages
// are stalled until the bus acks, or until MAX_WAIT ACCESS cycles have
// elapsed, which aborts the access with timeout_err. Misaligned accesses
// never reach the bus. They complete at once with misalign_err.
//
// Ports
//   clock, reset                    clock, async active-high reset
//   valid_in, mem_read, mem_write   instruction valid and load/store controls
//   size, sign_ext                  access width (byte..dword), load extension
//   address, write_data             effective address, store data
//   alu_result_in                   ALU result passed through to MEM_WB
//   stall                           holds EX_MEM and all earlier stages
//   valid_out                       one-cycle completion pulse to MEM_WB
//   read_data_uit, alu_result_uit   registered load result and ALU result
//   bus_req, bus_we                 data bus request and write enable
//   bus_addr, bus_wdata, bus_be     dword address, lane-placed data, enables
//   bus_ack, bus_rdata              bus completion strobe and read data
//   misalign_err, timeout_err       one-cycle error pulses
module mem_access #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    input  logic [63:0] alu_result_in,
    output logic        stall,
    output logic        valid_out,
    output logic [63:0] read_data_uit,
    output logic [63:0] alu_result_uit,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_be,
    input  logic        bus_ack,
    input  logic [63:0] bus_rdata,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       off_r;
    logic [1:0]       size_r;
    logic             sign_r;
    logic [63:0]      alu_r;

    logic        mem_op;
    logic        aligned;
    logic [7:0]  be_mask;
    logic        timeout_hit;
    logic [63:0] shifted;
    logic [63:0] load_value;

    assign mem_op      = mem_read | mem_write;
    assign timeout_hit = (wait_cnt == LAST_WAIT);
    assign shifted     = bus_rdata >> {off_r, 3'b000};

    always_comb begin
        aligned = 1'b1;
        be_mask = 8'h01;
        case (size)
            2'b00: begin aligned = 1'b1;                  be_mask = 8'h01; end
            2'b01: begin aligned = ~address[0];           be_mask = 8'h03; end
            2'b10: begin aligned = (address[1:0] == 2'b0); be_mask = 8'h0F; end
            default: begin aligned = (address[2:0] == 3'b0); be_mask = 8'hFF; end
        endcase
    end

    always_comb begin
        load_value = '0;
        case (size_r)
            2'b00:   load_value = sign_r ? {{56{shifted[7]}},  shifted[7:0]}  : {56'b0, shifted[7:0]};
            2'b01:   load_value = sign_r ? {{48{shifted[15]}}, shifted[15:0]} : {48'b0, shifted[15:0]};
            2'b10:   load_value = sign_r ? {{32{shifted[31]}}, shifted[31:0]} : {32'b0, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

    // Stall is combinational so the upstream stages freeze in the same cycle
    // the access is recognised. It is released in the last ACCESS cycle. It is
    // also gated by reset so it reads 0 while reset is asserted.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            if (state == IDLE)
                stall = valid_in & mem_op & aligned;
            else
                stall = ~(bus_ack | timeout_hit);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            off_r          <= '0;
            size_r         <= '0;
            sign_r         <= 1'b0;
            alu_r          <= '0;
            valid_out      <= 1'b0;
            read_data_uit  <= '0;
            alu_result_uit <= '0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= '0;
            bus_wdata      <= '0;
            bus_be         <= '0;
            misalign_err   <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            valid_out    <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!mem_op) begin
                            valid_out      <= 1'b1;
                            alu_result_uit <= alu_result_in;
                            read_data_uit  <= '0;
                        end else if (!aligned) begin
                            valid_out      <= 1'b1;
                            misalign_err   <= 1'b1;
                            alu_result_uit <= alu_result_in;
                            read_data_uit  <= '0;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {address[63:3], 3'b000};
                            bus_be    <= be_mask << address[2:0];
                            bus_wdata <= write_data << {address[2:0], 3'b000};
                            off_r     <= address[2:0];
                            size_r    <= size;
                            sign_r    <= sign_ext;
                            alu_r     <= alu_result_in;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        state          <= IDLE;
                        bus_req        <= 1'b0;
                        bus_we         <= 1'b0;
                        valid_out      <= 1'b1;
                        alu_result_uit <= alu_r;
                        read_data_uit  <= bus_we ? '0 : load_value;
                    end else if (timeout_hit) begin
                        state          <= IDLE;
                        bus_req        <= 1'b0;
                        bus_we         <= 1'b0;
                        valid_out      <= 1'b1;
                        timeout_err    <= 1'b1;
                        alu_result_uit <= alu_r;
                        read_data_uit  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access with MAX_WAIT=4.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in, mem_read, mem_write, sign_ext;
    logic [1:0]  size;
    logic [63:0] address, write_data, alu_result_in;
    logic        stall, valid_out, bus_req, bus_we, bus_ack;
    logic [63:0] read_data_uit, alu_result_uit, bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_be;
    logic        misalign_err, timeout_err;

    int checks = 0;
    int errors = 0;

    mem_access #(.MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .sign_ext(sign_ext), .address(address), .write_data(write_data),
        .alu_result_in(alu_result_in), .stall(stall), .valid_out(valid_out),
        .read_data_uit(read_data_uit), .alu_result_uit(alu_result_uit),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .misalign_err(misalign_err),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 0; mem_read = 0; mem_write = 0; size = 2'b00; sign_ext = 0;
        address = '0; write_data = '0; alu_result_in = '0;
        bus_ack = 0; bus_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        #1;
        check("reset_valid_out", {63'b0, valid_out}, 64'd0);
        check("reset_bus_req",   {63'b0, bus_req},   64'd0);
        check("reset_stall",     {63'b0, stall},     64'd0);
        check("reset_read_data", read_data_uit,      64'd0);
        check("reset_alu",       alu_result_uit,     64'd0);
        tick();
        tick();
        reset = 0;

        // ALU-only pass-through
        valid_in = 1; alu_result_in = 64'h2A;
        #1;
        check("alu_stall", {63'b0, stall}, 64'd0);
        tick();
        check("alu_valid_out", {63'b0, valid_out}, 64'd1);
        check("alu_result",    alu_result_uit,     64'h2A);
        check("alu_read_data", read_data_uit,      64'd0);
        check("alu_stall2",    {63'b0, stall},     64'd0);
        valid_in = 0; alu_result_in = 64'h77;
        tick();
        check("alu_valid_drop", {63'b0, valid_out}, 64'd0);
        check("alu_hold",       alu_result_uit,     64'h2A);

        // Signed byte load, ack two cycles after bus_req
        valid_in = 1; mem_read = 1; address = 64'h1003; size = 2'b00; sign_ext = 1;
        alu_result_in = 64'h55;
        #1;
        check("lb_stall_idle", {63'b0, stall}, 64'd1);
        tick();
        valid_in = 0; mem_read = 0; address = 64'hFFFF; alu_result_in = 64'h99;
        #1;
        check("lb_bus_req",  {63'b0, bus_req}, 64'd1);
        check("lb_bus_we",   {63'b0, bus_we},  64'd0);
        check("lb_bus_addr", bus_addr,         64'h1000);
        check("lb_bus_be",   {56'b0, bus_be},  64'h08);
        check("lb_stall_a1", {63'b0, stall},   64'd1);
        tick();
        bus_ack = 1; bus_rdata = 64'h0000_0000_8000_0000;
        #1;
        check("lb_stall_ack", {63'b0, stall}, 64'd0);
        tick();
        bus_ack = 0; bus_rdata = '0;
        check("lb_valid_out", {63'b0, valid_out}, 64'd1);
        check("lb_read_data", read_data_uit,      64'hFFFF_FFFF_FFFF_FF80);
        check("lb_alu",       alu_result_uit,     64'h55);
        check("lb_bus_req0",  {63'b0, bus_req},   64'd0);
        tick();
        check("lb_valid_once", {63'b0, valid_out}, 64'd0);
        check("lb_hold",       read_data_uit,      64'hFFFF_FFFF_FFFF_FF80);

        // bus_ack outside ACCESS is ignored
        bus_ack = 1; bus_rdata = 64'h1234;
        tick();
        check("stray_ack_valid", {63'b0, valid_out}, 64'd0);
        check("stray_ack_req",   {63'b0, bus_req},   64'd0);
        bus_ack = 0; bus_rdata = '0;

        // Unsigned halfword load at lane 6
        valid_in = 1; mem_read = 1; address = 64'h5006; size = 2'b01; sign_ext = 0;
        tick();
        idle_inputs();
        check("lh_bus_be",   {56'b0, bus_be}, 64'hC0);
        check("lh_bus_addr", bus_addr,        64'h5000);
        bus_ack = 1; bus_rdata = 64'hABCD_0000_0000_0000;
        tick();
        bus_ack = 0;
        check("lh_valid_out", {63'b0, valid_out}, 64'd1);
        check("lh_read_data", read_data_uit,      64'h0000_0000_0000_ABCD);

        // Word store with mem_read also set, so it is treated as a store
        valid_in = 1; mem_read = 1; mem_write = 1; address = 64'h2004; size = 2'b10;
        write_data = 64'hDEADBEEF;
        tick();
        idle_inputs();
        check("sw_bus_we",    {63'b0, bus_we},  64'd1);
        check("sw_bus_be",    {56'b0, bus_be},  64'hF0);
        check("sw_bus_wdata", bus_wdata,        64'hDEADBEEF_0000_0000);
        check("sw_bus_addr",  bus_addr,         64'h2000);
        bus_ack = 1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus_ack = 0;
        check("sw_valid_out", {63'b0, valid_out}, 64'd1);
        check("sw_read_data", read_data_uit,      64'd0);
        tick();
        check("sw_valid_once", {63'b0, valid_out}, 64'd0);

        // Misaligned word load
        valid_in = 1; mem_read = 1; address = 64'h3002; size = 2'b10;
        #1;
        check("mis_stall", {63'b0, stall}, 64'd0);
        tick();
        idle_inputs();
        check("mis_bus_req",   {63'b0, bus_req},      64'd0);
        check("mis_err",       {63'b0, misalign_err}, 64'd1);
        check("mis_valid_out", {63'b0, valid_out},    64'd1);
        check("mis_read_data", read_data_uit,         64'd0);
        tick();
        check("mis_err_once",   {63'b0, misalign_err}, 64'd0);
        check("mis_valid_once", {63'b0, valid_out},    64'd0);

        // Timeout: stall for the IDLE cycle plus 3 ACCESS cycles
        valid_in = 1; mem_read = 1; address = 64'h4000; size = 2'b11;
        #1;
        check("to_stall_idle", {63'b0, stall}, 64'd1);
        tick();
        idle_inputs();
        check("to_stall_a1", {63'b0, stall}, 64'd1);
        tick();
        check("to_stall_a2", {63'b0, stall}, 64'd1);
        tick();
        check("to_stall_a3", {63'b0, stall}, 64'd1);
        tick();
        check("to_stall_a4",   {63'b0, stall},     64'd0);
        check("to_no_valid",   {63'b0, valid_out}, 64'd0);
        check("to_req_still",  {63'b0, bus_req},   64'd1);
        tick();
        check("to_err",       {63'b0, timeout_err}, 64'd1);
        check("to_valid_out", {63'b0, valid_out},   64'd1);
        check("to_read_data", read_data_uit,        64'd0);
        check("to_bus_req0",  {63'b0, bus_req},     64'd0);
        tick();
        check("to_err_once", {63'b0, timeout_err}, 64'd0);

        // Reset in the second ACCESS cycle
        valid_in = 1; mem_read = 1; address = 64'h6008; size = 2'b11;
        tick();
        idle_inputs();
        tick();
        check("rst_pre_req", {63'b0, bus_req}, 64'd1);
        #2;
        reset = 1;
        #1;
        check("rst_bus_req", {63'b0, bus_req}, 64'd0);
        check("rst_stall",   {63'b0, stall},   64'd0);
        tick();
        reset = 0;
        bus_ack = 1;
        tick();
        check("rst_no_valid1", {63'b0, valid_out}, 64'd0);
        bus_ack = 0;
        tick();
        check("rst_no_valid2", {63'b0, valid_out}, 64'd0);

        // First valid instruction after reset is processed normally
        valid_in = 1; alu_result_in = 64'hC0FFEE;
        tick();
        valid_in = 0;
        check("post_rst_valid", {63'b0, valid_out}, 64'd1);
        check("post_rst_alu",   alu_result_uit,     64'hC0FFEE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the bus wait cycles in ACCESS before abort.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 valid_in  input  1  SHALL mark an instruction from EX_MEM.
REQ-005 mem_read, mem_write  input  1 each  SHALL be the load and store controls.
REQ-006 size  input  2  SHALL select the access width: 00 byte, 01 half, 10 word, 11 dword.
REQ-007 sign_ext  input  1  SHALL select sign extension (1) or zero extension (0) for loads.
REQ-008 address, write_data, alu_result_in  input  64 each  SHALL carry the effective address, store data and ALU result.
REQ-009 stall  output  1  SHALL hold EX_MEM and all earlier stages.
REQ-010 valid_out  output  1  SHALL be a registered one-cycle pulse per completed instruction toward MEM_WB.
REQ-011 read_data_uit, alu_result_uit  output  64 each  SHALL be the registered load result and ALU result for MEM_WB.
REQ-012 bus_req, bus_we  output  1 each  SHALL be the registered data-bus request and write-enable.
REQ-013 bus_addr, bus_wdata  output  64 each  SHALL be the dword-aligned address and lane-placed store data.
REQ-014 bus_be  output  8  SHALL be the byte enables.
REQ-015 bus_ack  input  1 and bus_rdata  input  64  SHALL be the completion strobe and read data.
REQ-016 misalign_err, timeout_err  output  1 each  SHALL be registered one-cycle error pulses.

Function
REQ-017 The FSM SHALL have two states: IDLE and ACCESS.
REQ-018 In IDLE, valid_in with neither mem_read nor mem_write SHALL produce valid_out=1, alu_result_uit=alu_result_in and read_data_uit=0 on the next edge (1-cycle latency, no stall).
REQ-019 The address SHALL be aligned when address modulo (1<<size) is 0.
REQ-020 In IDLE, a misaligned memory operation SHALL make no bus access and SHALL pulse valid_out and misalign_err on the next edge with read_data_uit=0.
REQ-021 In IDLE, an aligned memory operation SHALL assert stall combinationally in the same cycle.
REQ-022 On the next edge it SHALL enter ACCESS and register bus_req=1, bus_we=mem_write and bus_addr={address[63:3],000}.
REQ-023 On that same edge it SHALL register the byte offset, size, sign_ext and alu_result_in.
REQ-024 When mem_read and mem_write are both 1, the operation SHALL be a store.
REQ-025 bus_be SHALL be (2^(1<<size))-1 shifted left by address[2:0].
REQ-026 bus_wdata SHALL be write_data shifted left by 8*address[2:0].
REQ-027 In ACCESS, stall SHALL be 1 except in the cycle bus_ack=1 or the wait counter equals MAX_WAIT-1.
REQ-028 In ACCESS, valid_in and the other upstream inputs SHALL be ignored.
REQ-029 On bus_ack in ACCESS, the block SHALL return to IDLE on the next edge with bus_req=0 and valid_out=1.
REQ-030 On that edge, a load SHALL set read_data_uit = bus_rdata shifted right by 8*offset, truncated to size and extended per sign_ext; a store SHALL set read_data_uit=0.
REQ-031 The wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without bus_ack.
REQ-032 On reaching MAX_WAIT-1 without bus_ack, the block SHALL return to IDLE on the next edge with bus_req=0, valid_out=1, timeout_err=1 and read_data_uit=0.
REQ-033 bus_ack and timeout in the same cycle SHALL be resolved as bus_ack.
REQ-034 bus_ack outside ACCESS SHALL be ignored.
REQ-035 valid_out, misalign_err and timeout_err SHALL be 0 in every cycle not named above.
REQ-036 read_data_uit and alu_result_uit SHALL hold their values while valid_out=0.

Reset
REQ-037 Reset SHALL force IDLE, counter=0, stall=0 and all registered outputs to 0 immediately, without waiting for a clock edge.
REQ-038 Reset during ACCESS SHALL drop bus_req at once and SHALL produce no valid_out for the aborted instruction.
REQ-039 After reset deasserts, the first edge with valid_in=1 SHALL be processed normally.

Verification
REQ-040 ALU-only: valid_in=1, alu_result_in=0x2A -> next edge valid_out=1, alu_result_uit=0x2A, read_data_uit=0, stall=0 throughout.
REQ-041 Signed byte load: address=0x1003, size=00, sign_ext=1, bus_ack two cycles after bus_req with bus_rdata=0x0000_0000_8000_0000 -> bus_be=0x08, bus_addr=0x1000, read_data_uit=0xFFFF_FFFF_FFFF_FF80.
REQ-042 Word store: address=0x2004, size=10, write_data=0xDEADBEEF -> bus_we=1, bus_be=0xF0, bus_wdata=0xDEADBEEF_0000_0000; valid_out pulses once after ack.
REQ-043 Misaligned load: address=0x3002, size=10 -> no bus_req, misalign_err=1, valid_out=1 for exactly one cycle.
REQ-044 Timeout: MAX_WAIT=4, ack never asserted -> stall high 4 cycles (IDLE cycle plus 3 ACCESS cycles), then timeout_err=1, valid_out=1, read_data_uit=0.
REQ-045 Reset mid-access: assert reset in the second ACCESS cycle -> bus_req=0 and stall=0 immediately; no valid_out after release.
